// File: rtl/alu_issue_ctrl.sv
// Request/response front end for the combinational ALU: registers operands onto the ALU,
// captures its result one cycle later, screens illegal opcodes and counts completed responses.
module alu_issue_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_control,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  a_q, b_q, res_q;
  logic [2:0]       ctl_q;
  logic [TAG_W-1:0] tag_q;
  logic             zero_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, rsp_fire, op_legal;

  assign accept   = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_comb begin
    op_legal = 1'b0;
    case (ctl_q)
      3'b000, 3'b001, 3'b010, 3'b110: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The unused encoding falls into the default arm and returns to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = rsp_fire ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = rst_n;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      ctl_q  <= '0;
      tag_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        ctl_q <= req_op;
        tag_q <= req_tag;
      end
      if (state_q == EXEC) begin
        if (op_legal) begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          err_q  <= 1'b0;
        end else begin
          res_q  <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (rsp_fire && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = ctl_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;
  assign rsp_tag     = tag_q;
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; a second instance with CNT_W=2
// exercises counter saturation.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  req_op, alu_control;
  logic [3:0]  req_tag, rsp_tag;
  logic        alu_zero, rsp_zero, rsp_err;
  logic [15:0] op_count;

  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [31:0] s_req_a, s_req_b, s_alu_a, s_alu_b, s_alu_result, s_rsp_result;
  logic [2:0]  s_req_op, s_alu_control;
  logic [3:0]  s_rsp_tag;
  logic        s_alu_zero, s_rsp_zero, s_rsp_err;
  logic [1:0]  s_op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Illegal codes return garbage with zero=1 so a leak into the response is visible.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result}     = alu_model(alu_a, alu_b, alu_control);
  assign {s_alu_zero, s_alu_result} = alu_model(s_alu_a, s_alu_b, s_alu_control);

  alu_issue_ctrl #(.XLEN(32), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .op_count(op_count)
  );

  alu_issue_ctrl #(.XLEN(32), .TAG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .req_op(s_req_op), .req_tag(4'h0),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_control(s_alu_control),
    .alu_result(s_alu_result), .alu_zero(s_alu_zero),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_err(s_rsp_err), .rsp_tag(s_rsp_tag),
    .op_count(s_op_count)
  );

  // Presents a request and returns #1 after the accepting edge (DUT then in EXEC).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
    int n;
    n = 0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic to_resp();
    int n;
    n = 0;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_control} !== 67'd0) begin errors++; $display("FAIL rst_alu: got %h %h %b expected 0", alu_a, alu_b, alu_control); end
    checks++; if ({rsp_result, rsp_zero, rsp_err, rsp_tag, op_count} !== 54'd0) begin errors++; $display("FAIL rst_rsp: got %h %b %b %h %0d expected 0", rsp_result, rsp_zero, rsp_err, rsp_tag, op_count); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    issue(32'd5, 32'd7, 3'b010, 4'd3);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid: got %b expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_control} !== {32'd5, 32'd7, 3'b010}) begin errors++; $display("FAIL add_alu_inputs: got %h %h %b expected 5 7 010", alu_a, alu_b, alu_control); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: rsp_valid=%b expected 1", rsp_valid); end
    checks++; if ({rsp_result, rsp_zero, rsp_err, rsp_tag} !== {32'd12, 1'b0, 1'b0, 4'd3}) begin errors++; $display("FAIL add_rsp: got %h z=%b e=%b t=%h expected 0000000c 0 0 3", rsp_result, rsp_zero, rsp_err, rsp_tag); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL add_resp_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL add_back_idle: valid/ready got %b%b expected 01", rsp_valid, req_ready); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", op_count); end
    checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL add_result_kept: got %h expected 0000000c", rsp_result); end
  endtask

  task automatic test_sub();
    issue(32'd9, 32'd9, 3'b110, 4'd1);
    to_resp();
    checks++; if ({rsp_result, rsp_zero, rsp_err, rsp_tag} !== {32'd0, 1'b1, 1'b0, 4'd1}) begin errors++; $display("FAIL sub_zero: got %h z=%b e=%b t=%h expected 0 1 0 1", rsp_result, rsp_zero, rsp_err, rsp_tag); end
    handshake();
    checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL sub_count1: got %0d expected 2", op_count); end
    issue(32'd0, 32'd1, 3'b110, 4'd2);
    to_resp();
    checks++; if ({rsp_result, rsp_zero, rsp_err, rsp_tag} !== {32'hFFFF_FFFF, 1'b0, 1'b0, 4'd2}) begin errors++; $display("FAIL sub_wrap: got %h z=%b e=%b t=%h expected ffffffff 0 0 2", rsp_result, rsp_zero, rsp_err, rsp_tag); end
    handshake();
    checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL sub_count2: got %0d expected 3", op_count); end
  endtask

  task automatic test_illegal();
    issue(32'd1, 32'd1, 3'b111, 4'hA);
    checks++; if (alu_control !== 3'b111) begin errors++; $display("FAIL ill_control: got %b expected 111", alu_control); end
    to_resp();
    checks++; if ({rsp_result, rsp_zero, rsp_err, rsp_tag} !== {32'd0, 1'b0, 1'b1, 4'hA}) begin errors++; $display("FAIL ill_rsp: got %h z=%b e=%b t=%h expected 0 0 1 a", rsp_result, rsp_zero, rsp_err, rsp_tag); end
    handshake();
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL ill_count: got %0d expected 4", op_count); end
  endtask

  task automatic test_stall();
    issue(32'h0000_1234, 32'h0000_0F0F, 3'b001, 4'd9);
    to_resp();
    req_a = 32'd77; req_b = 32'd1; req_op = 3'b010; req_tag = 4'd6; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready, rsp_result, rsp_tag} !== {1'b1, 1'b0, 32'h0000_1F3F, 4'd9}) begin errors++; $display("FAIL stall_hold[%0d]: v=%b r=%b res=%h t=%h expected 1 0 00001f3f 9", i, rsp_valid, req_ready, rsp_result, rsp_tag); end
      checks++; if (alu_a !== 32'h0000_1234) begin errors++; $display("FAIL stall_alu_a[%0d]: got %h expected 00001234", i, alu_a); end
    end
    handshake();
    req_valid = 1'b0;
    checks++; if ({rsp_valid, req_ready, alu_a, op_count} !== {1'b0, 1'b1, 32'h0000_1234, 16'd5}) begin errors++; $display("FAIL stall_release: v=%b r=%b a=%h cnt=%0d expected 0 1 00001234 5", rsp_valid, req_ready, alu_a, op_count); end
    @(posedge clk); #1;
    checks++; if ({req_ready, alu_a} !== {1'b1, 32'h0000_1234}) begin errors++; $display("FAIL stall_no_accept: r=%b a=%h expected 1 00001234", req_ready, alu_a); end
  endtask

  task automatic test_reset_mid();
    issue(32'd3, 32'd4, 3'b010, 4'd5);
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b00) begin errors++; $display("FAIL midrst_hs: v=%b r=%b expected 0 0", rsp_valid, req_ready); end
    checks++; if ({alu_a, alu_b, alu_control, rsp_result, rsp_tag, op_count} !== 119'd0) begin errors++; $display("FAIL midrst_regs: a=%h res=%h t=%h cnt=%0d expected 0", alu_a, rsp_result, rsp_tag, op_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL midrst_after[%0d]: v=%b r=%b expected 0 1", i, rsp_valid, req_ready); end
    end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", op_count); end
  endtask

  task automatic test_saturation();
    logic [31:0] ta[5], tb[5], tr[5];
    logic [2:0]  top[5];
    logic        tz[5];
    logic [1:0]  tc[5];
    int          n;
    ta[0] = 32'hF0F0_F0F0; tb[0] = 32'hFF00_FF00; top[0] = 3'b000; tr[0] = 32'hF000_F000; tz[0] = 1'b0; tc[0] = 2'd1;
    ta[1] = 32'hF0F0_F0F0; tb[1] = 32'hFF00_FF00; top[1] = 3'b001; tr[1] = 32'hFFF0_FFF0; tz[1] = 1'b0; tc[1] = 2'd2;
    ta[2] = 32'h0000_00FF; tb[2] = 32'h0000_0F0F; top[2] = 3'b000; tr[2] = 32'h0000_000F; tz[2] = 1'b0; tc[2] = 2'd3;
    ta[3] = 32'h0000_0001; tb[3] = 32'h0000_0002; top[3] = 3'b001; tr[3] = 32'h0000_0003; tz[3] = 1'b0; tc[3] = 2'd3;
    ta[4] = 32'hAAAA_AAAA; tb[4] = 32'h5555_5555; top[4] = 3'b000; tr[4] = 32'h0000_0000; tz[4] = 1'b1; tc[4] = 2'd3;
    checks++; if (s_op_count !== 2'd0) begin errors++; $display("FAIL sat_start: got %0d expected 0", s_op_count); end
    s_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_req_a = ta[i]; s_req_b = tb[i]; s_req_op = top[i]; s_req_valid = 1'b1;
      n = 0;
      while (!s_req_ready && n < 8) begin @(posedge clk); #1; n++; end
      if (!s_req_ready) begin checks++; errors++; $display("FAIL sat_accept_timeout[%0d]: ready=%b required 1", i, s_req_ready); end
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({s_rsp_valid, s_rsp_result, s_rsp_zero, s_rsp_err} !== {1'b1, tr[i], tz[i], 1'b0}) begin errors++; $display("FAIL sat_rsp[%0d]: v=%b res=%h z=%b e=%b expected 1 %h %b 0", i, s_rsp_valid, s_rsp_result, s_rsp_zero, s_rsp_err, tr[i], tz[i]); end
      @(posedge clk); #1;
      checks++; if (s_op_count !== tc[i]) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, s_op_count, tc[i]); end
    end
    s_rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0; rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_a = '0; s_req_b = '0; s_req_op = '0; s_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
